// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: merges pipe results and queued mult/div results into one register-file write per cycle.
// Optional read-port forwarding is enabled by defining WB_FWD_EN.
module wb_write_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_valid,
  input  logic [4:0]    wb_reg,
  input  logic [31:0]   wb_data,
  input  logic          md_valid,
  input  logic [4:0]    md_reg,
  input  logic [31:0]   md_data,
  output logic          md_ready,
  output logic [4:0]    writereg,
  output logic          regwrite,
  output logic [31:0]   writedata,
  input  logic [4:0]    readreg1,
  input  logic [4:0]    readreg2,
  output logic          fwd1_hit,
  output logic [31:0]   fwd1_data,
  output logic          fwd2_hit,
  output logic [31:0]   fwd2_data,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [4:0]       ent_reg_r  [DEPTH];
  logic [31:0]      ent_data_r [DEPTH];
  logic [DEPTH-1:0] ent_vld_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_s;
  logic             pop_s;

  // Full FIFO refuses md input even when draining; no bypass path.
  assign md_ready   = (count_r != CNT_FULL);
  assign push_s     = md_valid && md_ready;
  assign pop_s      = !wb_valid && (count_r != {(AW+1){1'b0}});
  assign fifo_count = count_r;

  // FIFO storage, supersede invalidation, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg_r[i]  <= 5'd0;
        ent_data_r[i] <= 32'd0;
      end
      ent_vld_r <= {DEPTH{1'b0}};
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= {(AW+1){1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wb_valid && ent_vld_r[i] && (ent_reg_r[i] == wb_reg)) begin
          ent_vld_r[i] <= 1'b0;
        end
      end
      if (pop_s) begin
        ent_vld_r[rd_ptr_r] <= 1'b0;
        rd_ptr_r            <= rd_ptr_r + PTR_ONE;
      end
      // A push never targets the popped slot, and a same-cycle push is younger than wb so stays valid.
      if (push_s) begin
        ent_reg_r[wr_ptr_r]  <= md_reg;
        ent_data_r[wr_ptr_r] <= md_data;
        ent_vld_r[wr_ptr_r]  <= 1'b1;
        wr_ptr_r             <= wr_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered register-file write port with fixed pipe-over-FIFO priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite  <= 1'b0;
      writereg  <= 5'd0;
      writedata <= 32'd0;
    end else if (wb_valid) begin
      regwrite  <= (wb_reg != 5'd0);
      writereg  <= wb_reg;
      writedata <= wb_data;
    end else if (pop_s) begin
      regwrite  <= ent_vld_r[rd_ptr_r] && (ent_reg_r[rd_ptr_r] != 5'd0);
      writereg  <= ent_reg_r[rd_ptr_r];
      writedata <= ent_data_r[rd_ptr_r];
    end else begin
      regwrite  <= 1'b0;
      writereg  <= writereg;
      writedata <= writedata;
    end
  end

`ifdef WB_FWD_EN
  // Output stage first, then FIFO oldest to youngest, so the youngest queued match overrides.
  function automatic logic [32:0] fwd_lookup(input logic [4:0] rr);
    logic [32:0]   res;
    logic [AW-1:0] idx;
    res = {1'b0, 32'd0};
    idx = {AW{1'b0}};
    if (rr != 5'd0) begin
      if (regwrite && (writereg == rr)) begin
        res = {1'b1, writedata};
      end else begin
        res = {1'b0, 32'd0};
      end
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_r + AW'(i);
        if (ent_vld_r[idx] && (ent_reg_r[idx] == rr)) begin
          res = {1'b1, ent_data_r[idx]};
        end else begin
          res = res;
        end
      end
    end else begin
      res = {1'b0, 32'd0};
    end
    return res;
  endfunction

  // Combinational forwarding for both monitored read ports
  always_comb begin
    {fwd1_hit, fwd1_data} = fwd_lookup(readreg1);
    {fwd2_hit, fwd2_data} = fwd_lookup(readreg2);
  end
`else
  logic unused_readreg_s;
  assign unused_readreg_s = ^{readreg1, readreg2};

  // Forwarding disabled: outputs tied off
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = 32'd0;
    fwd2_hit  = 1'b0;
    fwd2_data = 32'd0;
  end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Directed self-checking bench for wb_write_sequencer; forwarding checks follow WB_FWD_EN.
module tb_wb_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  writereg;
  logic        regwrite;
  logic [31:0] writedata;
  logic [4:0]  readreg1;
  logic [4:0]  readreg2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  fifo_count;

  int checks_s   = 0;
  int failures_s = 0;

  wb_write_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .writereg(writereg), .regwrite(regwrite), .writedata(writedata),
    .readreg1(readreg1), .readreg2(readreg2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_s++;
    if (got !== exp) begin
      failures_s++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic rw, input logic [4:0] rg, input logic [31:0] d);
    check({tag, "_rw"}, 32'(regwrite), 32'(rw));
    if (rw) begin
      check({tag, "_reg"}, 32'(writereg), 32'(rg));
      check({tag, "_data"}, writedata, d);
    end
  endtask

  initial begin
    rst_n = 1'b0; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_reg = 5'd0; md_data = 32'd0;
    readreg1 = 5'd0; readreg2 = 5'd0;
    #12;
    check("rst_rw", 32'(regwrite), 32'd0);
    check("rst_reg", 32'(writereg), 32'd0);
    check("rst_data", writedata, 32'd0);
    check("rst_cnt", 32'(fifo_count), 32'd0);
    check("rst_rdy", 32'(md_ready), 32'd1);
    check("rst_hit", 32'(fwd1_hit), 32'd0);
    rst_n = 1'b1;
    tick();

    // single pipe write
    wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    tick();
    check_wr("wb5", 1'b1, 5'd5, 32'h1234);
    wb_valid = 1'b0;
    tick();
    check("wb5_off", 32'(regwrite), 32'd0);
    check("wb5_hold", 32'(writereg), 32'd5);

    // fill FIFO while the pipe holds the write port
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'(10 + i); wb_data = 32'h500 + 32'(i);
      md_valid = 1'b1; md_reg = 5'(1 + i); md_data = 32'h100 + 32'(i);
      tick();
    end
    check_wr("wb13", 1'b1, 5'd13, 32'h503);
    check("full_cnt", 32'(fifo_count), 32'd4);
    check("full_rdy", 32'(md_ready), 32'd0);
    wb_reg = 5'd14; md_reg = 5'd20; md_data = 32'hDEAD;
    tick();
    check("full_refuse_cnt", 32'(fifo_count), 32'd4);
    // drain while md still offers: push refused, pop proceeds
    wb_valid = 1'b0;
    tick();
    check_wr("drain1", 1'b1, 5'd1, 32'h100);
    check("drain1_cnt", 32'(fifo_count), 32'd3);
    check("drain1_rdy", 32'(md_ready), 32'd1);
    md_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_wr("drain", 1'b1, 5'(1 + i), 32'h100 + 32'(i));
    end
    tick();
    check("drain_end_rw", 32'(regwrite), 32'd0);
    check("drain_end_cnt", 32'(fifo_count), 32'd0);

    // supersede: queued reg7 overtaken by pipe reg7
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'hAAAA;
    tick();
    check("sup_push_rw", 32'(regwrite), 32'd0);
    check("sup_push_cnt", 32'(fifo_count), 32'd1);
    md_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd7; wb_data = 32'hBBBB;
    tick();
    check_wr("sup_wb", 1'b1, 5'd7, 32'hBBBB);
    check("sup_wb_cnt", 32'(fifo_count), 32'd1);
    wb_valid = 1'b0;
    tick();
    check("sup_drop_rw", 32'(regwrite), 32'd0);
    check("sup_drop_cnt", 32'(fifo_count), 32'd0);

    // register 0 is never written
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hFFFF;
    tick();
    check("r0_md_cnt", 32'(fifo_count), 32'd1);
    md_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd0; wb_data = 32'h55;
    tick();
    check("r0_wb_rw", 32'(regwrite), 32'd0);
    wb_valid = 1'b0;
    tick();
    check("r0_pop_rw", 32'(regwrite), 32'd0);
    check("r0_pop_cnt", 32'(fifo_count), 32'd0);

    // forwarding: two queued reg9 results, output stage holds reg31
    wb_valid = 1'b1; wb_reg = 5'd30; wb_data = 32'h3030;
    md_valid = 1'b1; md_reg = 5'd9; md_data = 32'h11;
    tick();
    wb_reg = 5'd31; wb_data = 32'h3131; md_data = 32'h22;
    tick();
    md_valid = 1'b0; wb_reg = 5'd30; wb_data = 32'h3030;
    readreg1 = 5'd9; readreg2 = 5'd0;
    #1;
`ifdef WB_FWD_EN
    check("fwd1_hit", 32'(fwd1_hit), 32'd1);
    check("fwd1_data", fwd1_data, 32'h22);
`else
    check("fwd1_hit", 32'(fwd1_hit), 32'd0);
    check("fwd1_data", fwd1_data, 32'd0);
`endif
    check("fwd2_r0_hit", 32'(fwd2_hit), 32'd0);
    check("fwd2_r0_data", fwd2_data, 32'd0);
    readreg2 = 5'd31;
    #1;
`ifdef WB_FWD_EN
    check("fwd2_out_hit", 32'(fwd2_hit), 32'd1);
    check("fwd2_out_data", fwd2_data, 32'h3131);
`else
    check("fwd2_out_hit", 32'(fwd2_hit), 32'd0);
`endif
    readreg2 = 5'd12;
    #1;
    check("fwd2_miss", 32'(fwd2_hit), 32'd0);
    tick();
    wb_valid = 1'b0;
    tick();
    check_wr("fwd_drain1", 1'b1, 5'd9, 32'h11);
    tick();
    check_wr("fwd_drain2", 1'b1, 5'd9, 32'h22);
    readreg1 = 5'd0; readreg2 = 5'd0;

    // asynchronous reset with queued results mid-drain
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_reg = 5'd15; wb_data = 32'h77;
      md_valid = 1'b1; md_reg = 5'(3 + i); md_data = 32'h900 + 32'(i);
      tick();
    end
    wb_valid = 1'b0; md_valid = 1'b0;
    tick();
    check_wr("rst_mid_pop", 1'b1, 5'd3, 32'h900);
    check("rst_mid_cnt", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rw", 32'(regwrite), 32'd0);
    check("arst_reg", 32'(writereg), 32'd0);
    check("arst_data", writedata, 32'd0);
    check("arst_cnt", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_rw", 32'(regwrite), 32'd0);
      check("post_rst_cnt", 32'(fifo_count), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule

// File: doc/wb_write_sequencer.md
Name: wb_write_sequencer

Overview:
- Write-side initiator for the 32x32 register file.
- Sits at the end of the pipeline. Collects results from the single-cycle pipe (ALU/load) and from the multi-cycle mult/div unit.
- Buffers mult/div results in a small FIFO and drives exactly one register-file write per clock (writereg/regwrite/writedata).
- Provides read-port forwarding of results the register file does not hold yet.

Parameters:
- DEPTH, 4, mult/div result FIFO entries (power of 2, >=2).
- AW, 2, FIFO pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wb_valid  in  1  pipe result valid this cycle.
- wb_reg  in  5  pipe destination register.
- wb_data  in  32  pipe result.
- md_valid  in  1  mult/div result offered.
- md_reg  in  5  mult/div destination register.
- md_data  in  32  mult/div result.
- md_ready  out  1  FIFO can accept; md transfer occurs when md_valid && md_ready.
- writereg  out  5  register-file write address.
- regwrite  out  1  register-file write enable.
- writedata  out  32  register-file write data.
- readreg1  in  5  register-file read address 1 (monitored).
- readreg2  in  5  register-file read address 2 (monitored).
- fwd1_hit  out  1  pending write matches readreg1.
- fwd1_data  out  32  forwarded value for readreg1.
- fwd2_hit  out  1  pending write matches readreg2.
- fwd2_data  out  32  forwarded value for readreg2.
- fifo_count  out  AW+1  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - regwrite=0, writereg=0, writedata=0.
  - FIFO empty: count=0, pointers=0, all entry valid bits cleared.
  - md_ready=1; fwd hits=0, fwd data=0.
  - Reset mid-operation discards all queued results; nothing is written after deassertion until new input.
- Output stage: writereg/regwrite/writedata are registers.
  - An input selected at edge N appears on the outputs during cycle N+1.
  - The register file commits it at edge N+1.
- Per-cycle selection, fixed priority:
  1. wb_valid=1: output stage loads wb_reg/wb_data; the FIFO does not drain.
  2. Else FIFO non-empty: output stage loads the FIFO head, which is popped.
  3. Else regwrite<=0; writereg/writedata hold their previous values.
- Register 0: any selected write with destination 0 produces regwrite=0 and is still consumed (popped if from FIFO). md results for reg 0 are accepted and dropped at drain.
- Supersede rule: when wb_valid=1, every valid FIFO entry whose reg == wb_reg is invalidated in the same edge.
  - Invalidated entries stay in the FIFO and still occupy count.
  - When one reaches the head it is popped with regwrite=0.
- FIFO:
  - md_ready = (fifo_count != DEPTH), combinational from count only.
  - Push when md_valid && md_ready. Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Full with simultaneous drain: md_ready stays 0 that cycle (no bypass); the push is refused.
  - md_valid while full: no state change; the producer holds its data.
  - A push into an empty FIFO is not eligible for draining in the same cycle; it drains at the earliest next cycle.
- Forwarding (combinational from readreg1/2 and state):
  - Sources: valid FIFO entries (youngest match wins), then the output stage (regwrite=1).
  - A readreg of 0 never hits.
  - No match: hit=0, data=0.
  - An output-stage value is visible for exactly the cycle before the register file commits it.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: forwarding logic as specified above.
- Undefined: fwd1_hit=fwd2_hit=0 and fwd1_data=fwd2_data=0 constantly; no comparators are synthesised; the rest of the behaviour is unchanged.

Test Plan:
- Reset hold, then wb_valid=1, wb_reg=5, wb_data=0x1234 at edge N -> cycle N+1: regwrite=1, writereg=5, writedata=0x1234; cycle N+2: regwrite=0.
- Push md results to regs 1,2,3,4 with wb_valid held 1 (to regs 10..13) -> fifo_count=4, md_ready=0. Release wb_valid -> regs 1,2,3,4 written on 4 consecutive cycles in order; md_ready=1 after the first pop.
- Queue md entry reg 7 = 0xAAAA, then wb_valid reg 7 = 0xBBBB -> reg 7 written once with 0xBBBB; the later drain of the 0xAAAA entry gives regwrite=0.
- md_valid reg 0 = 0xFFFF, and wb_valid reg 0 -> regwrite never asserted; FIFO returns to empty.
- WB_FWD_EN defined: FIFO holds reg 9 = 0x11 then reg 9 = 0x22, readreg1=9 -> fwd1_hit=1, fwd1_data=0x22. readreg2=0 -> fwd2_hit=0. Macro undefined -> both hits 0.
- Assert rst_n=0 with 3 queued entries mid-drain -> outputs 0 immediately (asynchronous); after release fifo_count=0 and no writes occur.
